// File: rtl/prod_accum.sv
// prod_accum: sums LEN signed products per group, one per p_done rising edge; result held until sum_ready (never stalls upstream).
// Result valid the cycle after the completing acceptance; PROD_ACCUM_SAT_EN selects clamping instead of wrapping adds.
module prod_accum #(
  parameter int LEN   = 4,
  parameter int ACC_W = 24
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [15:0]      p_in,
  input  logic                    p_done,
  input  logic                    clr,
  output logic signed [ACC_W-1:0] sum,
  output logic                    sum_valid,
  input  logic                    sum_ready,
  output logic                    busy,
  output logic                    ovr,
  output logic                    sat
);
  localparam int CNT_W = $clog2(LEN + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(LEN - 1);
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  typedef enum logic {IDLE = 1'b0, ACCUM = 1'b1} state_t;

  state_t                  state, state_nx;
  logic signed [ACC_W-1:0] acc, acc_nx, p_ext, add_wrap, add_res;
  logic [CNT_W-1:0]        cnt, cnt_nx;
  logic                    done_q, armed, accept, ovf, complete, load;
  logic                    sum_valid_nx, ovr_nx, sat_nx;

  assign p_ext    = ACC_W'(p_in);
  assign add_wrap = acc + p_ext;
  assign ovf      = (acc[ACC_W-1] == p_ext[ACC_W-1]) && (add_wrap[ACC_W-1] != acc[ACC_W-1]);

`ifdef PROD_ACCUM_SAT_EN
  assign add_res = ovf ? (acc[ACC_W-1] ? ACC_MIN : ACC_MAX) : add_wrap;
`else
  assign add_res = add_wrap;
`endif

  // armed blocks a p_done that is already high when reset releases from counting as an edge
  assign accept = p_done && !done_q && armed;
  assign busy   = (cnt != '0);

  always_comb begin
    state_nx = state;
    acc_nx   = acc;
    cnt_nx   = cnt;
    complete = 1'b0;
    ovr_nx   = ovr;
    sat_nx   = sat;
    if (clr) begin
      state_nx = IDLE;
      acc_nx   = '0;
      cnt_nx   = '0;
      ovr_nx   = 1'b0;
      sat_nx   = 1'b0;
    end else if (accept) begin
      sat_nx = sat | ovf;
      case (state)
        IDLE: begin
          if (LEN == 1) begin
            complete = 1'b1;
          end else begin
            state_nx = ACCUM;
            acc_nx   = add_res;
            cnt_nx   = CNT_W'(1);
          end
        end
        ACCUM: begin
          if (cnt == LAST) begin
            complete = 1'b1;
          end else begin
            acc_nx = add_res;
            cnt_nx = cnt + CNT_W'(1);
          end
        end
        default: state_nx = IDLE;
      endcase
      if (complete) begin
        state_nx = IDLE;
        acc_nx   = '0;
        cnt_nx   = '0;
      end
    end
    load = complete && (!sum_valid || sum_ready);
    if (complete && sum_valid && !sum_ready) ovr_nx = 1'b1;
    sum_valid_nx = load || (sum_valid && !sum_ready);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      done_q    <= 1'b0;
      armed     <= 1'b0;
      sum       <= '0;
      sum_valid <= 1'b0;
      ovr       <= 1'b0;
      sat       <= 1'b0;
    end else begin
      state     <= state_nx;
      acc       <= acc_nx;
      cnt       <= cnt_nx;
      done_q    <= p_done;
      armed     <= armed | ~p_done;
      sum_valid <= sum_valid_nx;
      ovr       <= ovr_nx;
      sat       <= sat_nx;
      if (load) sum <= add_res;
    end
  end
endmodule

// File: tb/tb_prod_accum.sv
// Bench for prod_accum: three instances (LEN=4/ACC_W=24, LEN=1/ACC_W=24, LEN=4/ACC_W=16) share one stimulus stream.
module tb_prod_accum;
  logic clk = 1'b0, rst = 1'b0, p_done = 1'b0, clr = 1'b0, sum_ready = 1'b1;
  logic signed [15:0] p_in = '0;
  logic signed [23:0] sum4, sum1;
  logic signed [15:0] sum16;
  logic sv4, sv1, sv16, busy4, busy1, busy16, ovr4, ovr1, ovr16, sat4, sat1, sat16;
  int total = 0, bad = 0;
  int hs1 = 0;
  int last1 = 0;
  logic count_en = 1'b0;

  always #5 clk = ~clk;

  prod_accum #(.LEN(4), .ACC_W(24)) u4 (.clk(clk), .rst(rst), .p_in(p_in), .p_done(p_done), .clr(clr),
    .sum(sum4), .sum_valid(sv4), .sum_ready(sum_ready), .busy(busy4), .ovr(ovr4), .sat(sat4));
  prod_accum #(.LEN(1), .ACC_W(24)) u1 (.clk(clk), .rst(rst), .p_in(p_in), .p_done(p_done), .clr(clr),
    .sum(sum1), .sum_valid(sv1), .sum_ready(sum_ready), .busy(busy1), .ovr(ovr1), .sat(sat1));
  prod_accum #(.LEN(4), .ACC_W(16)) u16 (.clk(clk), .rst(rst), .p_in(p_in), .p_done(p_done), .clr(clr),
    .sum(sum16), .sum_valid(sv16), .sum_ready(sum_ready), .busy(busy16), .ovr(ovr16), .sat(sat16));

  always @(negedge clk) begin
    if (count_en && sv1 && sum_ready) begin
      hs1++;
      last1 = int'($signed(sum1));
    end
  end

  typedef struct {
    int p0, p1, p2, p3;
    int exp_sum;
  } vec_t;
  vec_t vecs [6];

  task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic send(input logic signed [15:0] v);
    @(posedge clk); #1 p_in = v; p_done = 1'b1;
    @(posedge clk); #1 p_done = 1'b0;
  endtask

  task automatic reset_pulse();
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
  endtask

  initial begin
    vecs[0] = '{35, 16384, 150, -1, 16568};
    vecs[1] = '{0, 0, 0, 0, 0};
    vecs[2] = '{-32768, -32768, -32768, -32768, -131072};
    vecs[3] = '{32767, 32767, 32767, 32767, 131068};
    vecs[4] = '{1, -2, 3, -4, -2};
    vecs[5] = '{100, 200, 300, -700, -100};

    // reset state
    @(negedge clk);
    chk("rst_sum", $signed(sum4), 0);
    chk("rst_sum_valid", sv4, 0);
    chk("rst_busy", busy4, 0);
    chk("rst_ovr", ovr4, 0);
    chk("rst_sat", sat4, 0);
    @(posedge clk); #1 rst = 1'b1;

    for (int i = 0; i < 6; i++) begin
      send(16'(vecs[i].p0));
      send(16'(vecs[i].p1));
      send(16'(vecs[i].p2));
      @(negedge clk);
      chk("busy_mid_group", busy4, 1);
      @(posedge clk); #1 p_in = 16'(vecs[i].p3); p_done = 1'b1;
      @(negedge clk);
      chk("valid_not_in_accept_cycle", sv4, 0);
      @(posedge clk); #1 p_done = 1'b0;
      @(negedge clk);
      chk("group_valid", sv4, 1);
      chk("group_sum", $signed(sum4), vecs[i].exp_sum);
      chk("group_busy", busy4, 0);
      chk("group_ovr", ovr4, 0);
      chk("group_sat", sat4, 0);
      @(negedge clk);
      chk("valid_one_cycle", sv4, 0);
    end

    // p_done held high 5 cycles counts once
    reset_pulse();
    hs1 = 0; count_en = 1'b1;
    @(posedge clk); #1 p_in = 16'sd35; p_done = 1'b1;
    repeat (5) @(posedge clk);
    #1 p_done = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("level_hold_count", hs1, 1);
    chk("level_hold_sum", last1, 35);

    // p_done high across reset release is not an edge
    @(posedge clk); #1 rst = 1'b0; p_in = 16'sd11; p_done = 1'b1;
    @(posedge clk); #1 rst = 1'b1; hs1 = 0;
    repeat (3) @(posedge clk);
    #1 p_done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("no_edge_after_reset", hs1, 0);
    send(16'sd11);
    repeat (2) @(negedge clk);
    #1;
    chk("edge_after_low", hs1, 1);
    chk("edge_after_low_sum", last1, 11);
    count_en = 1'b0;

    // overflow: wrap vs clamp on 16-bit accumulator
    reset_pulse();
    repeat (4) send(16'sd16384);
    @(negedge clk);
    chk("ovf16_valid", sv16, 1);
`ifdef PROD_ACCUM_SAT_EN
    chk("ovf16_sum", $signed(sum16), 32767);
`else
    chk("ovf16_sum", $signed(sum16), 0);
`endif
    chk("ovf16_sat", sat16, 1);
    chk("wide_sum", $signed(sum4), 65536);
    chk("wide_sat", sat4, 0);

    // held result, dropped group, clr keeps result
    reset_pulse();
    sum_ready = 1'b0;
    send(16'sd5);
    @(negedge clk);
    chk("hold_valid", sv1, 1);
    chk("hold_sum", $signed(sum1), 5);
    send(16'sd7);
    @(negedge clk);
    chk("drop_sum_kept", $signed(sum1), 5);
    chk("drop_ovr", ovr1, 1);
    @(posedge clk); #1 clr = 1'b1;
    @(posedge clk); #1 clr = 1'b0;
    @(negedge clk);
    chk("clr_ovr", ovr1, 0);
    chk("clr_keeps_valid", sv1, 1);
    chk("clr_keeps_sum", $signed(sum1), 5);
    sum_ready = 1'b1;
    @(negedge clk);
    chk("after_handshake_valid", sv1, 0);

    // reset mid-group discards partial sum
    reset_pulse();
    send(16'sd9);
    send(16'sd9);
    @(negedge clk);
    chk("partial_busy", busy4, 1);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_busy", busy4, 0);
    @(posedge clk); #1 rst = 1'b1;
    repeat (4) send(16'sd1);
    @(negedge clk);
    chk("post_reset_sum", $signed(sum4), 4);
    chk("post_reset_valid", sv4, 1);
    chk("post_reset_busy", busy4, 0);

    // clr coincident with third edge
    reset_pulse();
    send(16'sd2);
    send(16'sd2);
    @(posedge clk); #1 p_in = 16'sd2; p_done = 1'b1; clr = 1'b1;
    @(posedge clk); #1 p_done = 1'b0; clr = 1'b0;
    @(negedge clk);
    chk("clr_busy", busy4, 0);
    chk("clr_no_valid", sv4, 0);
    repeat (4) send(16'sd2);
    @(negedge clk);
    chk("clr_then_sum", $signed(sum4), 8);
    chk("clr_then_valid", sv4, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
